iob_system_tester_pbus_gate: RTL



---
 rtl/iob_system_tester_pbus_gate.sv | 114 +++++++++++
 1 files changed

// File: rtl/iob_system_tester_pbus_gate.sv
// Single-outstanding-read gate in front of the tester peripheral-bus splitter.
// Blocks new requests while a read is pending and terminates lost reads with an error word.
//
// state   | meaning
// IDLE    | requests pass through; rvalid from the splitter here is stray
// RD_WAIT | one read outstanding; requests blocked, timeout counter running
module iob_system_tester_pbus_gate #(
  parameter int                 ADDR_W    = 30,
  parameter int                 DATA_W    = 32,
  parameter int                 TIMEOUT_W = 8,
  parameter int unsigned        TIMEOUT   = 255,
  parameter logic [DATA_W-1:0]  ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                s_iob_valid_i,
  input  logic [ADDR_W-1:0]   s_iob_addr_i,
  input  logic [DATA_W-1:0]   s_iob_wdata_i,
  input  logic [DATA_W/8-1:0] s_iob_wstrb_i,
  output logic                s_iob_ready_o,
  output logic                s_iob_rvalid_o,
  output logic [DATA_W-1:0]   s_iob_rdata_o,
  output logic                m_iob_valid_o,
  output logic [ADDR_W-1:0]   m_iob_addr_o,
  output logic [DATA_W-1:0]   m_iob_wdata_o,
  output logic [DATA_W/8-1:0] m_iob_wstrb_o,
  input  logic                m_iob_ready_i,
  input  logic                m_iob_rvalid_i,
  input  logic [DATA_W-1:0]   m_iob_rdata_i,
  output logic                timeout_o,
  output logic                stray_o,
  input  logic                err_clr_i
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  localparam logic [TIMEOUT_W-1:0] TO_CNT = TIMEOUT_W'(TIMEOUT);
  localparam bit                   TO_EN  = (TIMEOUT != 0);

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   stray_q, stray_d;
  logic                   to_set, stray_set;

  assign m_iob_addr_o  = s_iob_addr_i;
  assign m_iob_wdata_o = s_iob_wdata_i;
  assign m_iob_wstrb_o = s_iob_wstrb_i;
  assign timeout_o     = timeout_q;
  assign stray_o       = stray_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    to_set         = 1'b0;
    stray_set      = 1'b0;
    m_iob_valid_o  = 1'b0;
    s_iob_ready_o  = 1'b0;
    s_iob_rvalid_o = 1'b0;
    s_iob_rdata_o  = m_iob_rdata_i;
    case (state_q)
      IDLE: begin
        m_iob_valid_o = s_iob_valid_i;
        s_iob_ready_o = m_iob_ready_i;
        stray_set     = m_iob_rvalid_i;
        if (s_iob_valid_i && m_iob_ready_i && (s_iob_wstrb_i == '0)) begin
          state_d = RD_WAIT;
          cnt_d   = '0;
        end
      end
      RD_WAIT: begin
        s_iob_rvalid_o = m_iob_rvalid_i;
        if (m_iob_rvalid_i) begin
          state_d = IDLE;
        end else if (TO_EN && (cnt_q == TO_CNT)) begin
          s_iob_rvalid_o = 1'b1;
          s_iob_rdata_o  = ERR_RDATA;
          to_set         = 1'b1;
          state_d        = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // a set event in the clear cycle wins
    timeout_d = to_set | (timeout_q & ~err_clr_i);
    stray_d   = stray_set | (stray_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      stray_q   <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
        stray_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        timeout_q <= timeout_d;
        stray_q   <= stray_d;
      end
    end
  end

endmodule
